// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM (package mcu_pkg).
// Contents:
//   opcode_e : RV32I major opcodes decoded by the FSM
//   state_e  : controller states
//   mux-select encodings for pcSrc, regSrc, immedSrc, aluSrcA, aluSrcB and aluOp
//   halt-cause encodings
//   ctrl_t   : bundle of every datapath control output, used internally by the top
package mcu_pkg;

  typedef enum logic [6:0] {
    OpcLoad   = 7'b0000011,
    OpcOpImm  = 7'b0010011,
    OpcAuipc  = 7'b0010111,
    OpcStore  = 7'b0100011,
    OpcOp     = 7'b0110011,
    OpcLui    = 7'b0110111,
    OpcBranch = 7'b1100011,
    OpcJalr   = 7'b1100111,
    OpcJal    = 7'b1101111,
    OpcSystem = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExec,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StBranch,
    StJump,
    StHalt
  } state_e;

  // pcSrc
  localparam logic [1:0] PcSrcAlu    = 2'd0;  // ALU result (PC+4)
  localparam logic [1:0] PcSrcTarget = 2'd1;  // oldPC + imm
  localparam logic [1:0] PcSrcJalr   = 2'd2;  // ALU result & ~1

  // regSrc
  localparam logic [1:0] RegSrcAlu  = 2'd0;
  localparam logic [1:0] RegSrcMem  = 2'd1;
  localparam logic [1:0] RegSrcLink = 2'd2;  // oldPC + 4
  localparam logic [1:0] RegSrcImm  = 2'd3;

  // immedSrc
  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  // aluSrcA
  localparam logic [1:0] ASrcRs1   = 2'd0;
  localparam logic [1:0] ASrcPc    = 2'd1;
  localparam logic [1:0] ASrcOldPc = 2'd2;
  localparam logic [1:0] ASrcZero  = 2'd3;

  // aluSrcB
  localparam logic [1:0] BSrcRs2  = 2'd0;
  localparam logic [1:0] BSrcImm  = 2'd1;
  localparam logic [1:0] BSrcFour = 2'd2;

  // aluOp
  localparam logic [2:0] AluAdd    = 3'd0;
  localparam logic [2:0] AluCmp    = 3'd1;
  localparam logic [2:0] AluRFunct = 3'd2;
  localparam logic [2:0] AluIFunct = 3'd3;

  // halt_cause
  localparam logic [1:0] HaltNone    = 2'd0;
  localparam logic [1:0] HaltError   = 2'd1;
  localparam logic [1:0] HaltIllegal = 2'd2;
  localparam logic [1:0] HaltTimeout = 2'd3;

  typedef struct packed {
    logic       pc_update;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       addr_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_src;
    logic       reg_write;
    logic [2:0] immed_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  // States that wait on the memory handshake and therefore run the watchdog.
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between mc_control_fsm and the datapath / memory.
// Inputs to the FSM : opcode, error, mem_ready, br_taken
// Outputs of the FSM: pcUpdate, pcSrc, irWrite, addrSrc, memRead, memWrite, regSrc, regWrite,
//                     immedSrc, aluSrcA, aluSrcB, aluOp, halted, halt_cause,
//                     cycle_cnt, instret_cnt (CNT_W wide)
// Modports: master = controller side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             error;
  logic             mem_ready;
  logic             br_taken;
  logic             pcUpdate;
  logic [1:0]       pcSrc;
  logic             irWrite;
  logic             addrSrc;
  logic             memRead;
  logic             memWrite;
  logic [1:0]       regSrc;
  logic             regWrite;
  logic [2:0]       immedSrc;
  logic [1:0]       aluSrcA;
  logic [1:0]       aluSrcB;
  logic [2:0]       aluOp;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  opcode, error, mem_ready, br_taken,
    output pcUpdate, pcSrc, irWrite, addrSrc, memRead, memWrite, regSrc, regWrite,
           immedSrc, aluSrcA, aluSrcB, aluOp, halted, halt_cause, cycle_cnt, instret_cnt
  );

  modport slave (
    output opcode, error, mem_ready, br_taken,
    input  pcUpdate, pcSrc, irWrite, addrSrc, memRead, memWrite, regSrc, regWrite,
           immedSrc, aluSrcA, aluSrcB, aluOp, halted, halt_cause, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/mc_control_fsm_wait_timer.sv
// mcu_wait_timer: memory-wait watchdog counter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   count_en_i  : a wait state is stalled on mem_ready this cycle
//   clear_i     : FSM is changing state; restart the count
//   expired_o   : this stalled cycle is the MEM_TIMEOUT-th in a row (never with MEM_TIMEOUT=0)
module mcu_wait_timer #(
  parameter int unsigned TMR_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned          LimitInt = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TMR_W-1:0]     Limit    = LimitInt[TMR_W-1:0];
  localparam bit                   Enabled  = (MEM_TIMEOUT != 0);

  logic [TMR_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_en_i && (timer_q != '1)) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = Enabled && count_en_i && (timer_q == Limit);

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control FSM driving datapath muxes and enables.
// Ports:
//   clk   : clock
//   rst_n : async active-low reset; while low every control output is forced to 0
//   bus   : mc_control_fsm_if.master (opcode/error/mem_ready/br_taken in, controls out)
// Parameters: MEM_TIMEOUT (0 disables the watchdog), CNT_W (counter width), TMR_W (timer width).
// Optional: define MCU_PERF_CNT_EN to build the cycle/instret counters; otherwise both
// outputs are tied to 0 and no counter flops exist.
module mc_control_fsm
  import mcu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TMR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_control_fsm_if.master    bus
);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       tmr_expired;
  logic       tmr_count_en;
  logic       tmr_clear;
  opcode_e    opc;
  ctrl_t      ctrl;

  assign opc = opcode_e'(bus.opcode);

  // Watchdog only runs while a memory handshake is stalled.
  assign tmr_count_en = is_wait_state(state_q) && !bus.mem_ready;
  assign tmr_clear    = (state_d != state_q);

  mcu_wait_timer #(
    .TMR_W      (TMR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_en_i(tmr_count_en),
    .clear_i   (tmr_clear),
    .expired_o (tmr_expired)
  );

  // Next state. mem_ready on the expiring cycle still advances normally; error overrides all.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_ready) begin
          state_d = StDecode;
        end else if (tmr_expired) begin
          state_d = StHalt;
          cause_d = HaltTimeout;
        end
      end
      StDecode: begin
        case (opc)
          OpcOp, OpcOpImm, OpcLui, OpcAuipc: state_d = StExec;
          OpcLoad, OpcStore:                 state_d = StMemAddr;
          OpcBranch:                         state_d = StBranch;
          OpcJal, OpcJalr:                   state_d = StJump;
          default: begin
            state_d = StHalt;
            cause_d = HaltIllegal;
          end
        endcase
      end
      StExec:    state_d = StFetch;
      StMemAddr: state_d = (opc == OpcLoad) ? StMemRd : StMemWr;
      StMemRd: begin
        if (bus.mem_ready) begin
          state_d = StMemWb;
        end else if (tmr_expired) begin
          state_d = StHalt;
          cause_d = HaltTimeout;
        end
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
        end else if (tmr_expired) begin
          state_d = StHalt;
          cause_d = HaltTimeout;
        end
      end
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default: begin
        state_d = StHalt;
        cause_d = HaltIllegal;
      end
    endcase

    // HALT is terminal, so the cause is written once per reset and stays sticky.
    if (bus.error && (state_q != StHalt)) begin
      state_d = StHalt;
      cause_d = HaltError;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cause_q <= HaltNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Moore decode of the current state; irWrite/pcUpdate are qualified by mem_ready/br_taken.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.addr_src  = 1'b0;
        ctrl.alu_src_a = ASrcPc;
        ctrl.alu_src_b = BSrcFour;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_src    = PcSrcAlu;
        if (bus.mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_update = 1'b1;
        end
      end
      StDecode: begin
      end
      StExec: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_src   = RegSrcAlu;
        case (opc)
          OpcOp: begin
            ctrl.alu_src_a = ASrcRs1;
            ctrl.alu_src_b = BSrcRs2;
            ctrl.alu_op    = AluRFunct;
          end
          OpcOpImm: begin
            ctrl.alu_src_a = ASrcRs1;
            ctrl.alu_src_b = BSrcImm;
            ctrl.immed_src = ImmI;
            ctrl.alu_op    = AluIFunct;
          end
          OpcLui: begin
            ctrl.alu_src_a = ASrcZero;
            ctrl.alu_src_b = BSrcImm;
            ctrl.immed_src = ImmU;
            ctrl.alu_op    = AluAdd;
          end
          OpcAuipc: begin
            ctrl.alu_src_a = ASrcOldPc;
            ctrl.alu_src_b = BSrcImm;
            ctrl.immed_src = ImmU;
            ctrl.alu_op    = AluAdd;
          end
          default: begin
          end
        endcase
      end
      StMemAddr: begin
        ctrl.alu_src_a = ASrcRs1;
        ctrl.alu_src_b = BSrcImm;
        ctrl.immed_src = (opc == OpcLoad) ? ImmI : ImmS;
        ctrl.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.addr_src = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_src   = RegSrcMem;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.addr_src  = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a = ASrcRs1;
        ctrl.alu_src_b = BSrcRs2;
        ctrl.alu_op    = AluCmp;
        ctrl.immed_src = ImmB;
        ctrl.pc_src    = PcSrcTarget;
        ctrl.pc_update = bus.br_taken;
      end
      StJump: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_src   = RegSrcLink;
        ctrl.pc_update = 1'b1;
        if (opc == OpcJalr) begin
          ctrl.alu_src_a = ASrcRs1;
          ctrl.alu_src_b = BSrcImm;
          ctrl.immed_src = ImmI;
          ctrl.alu_op    = AluAdd;
          ctrl.pc_src    = PcSrcJalr;
        end else begin
          ctrl.pc_src    = PcSrcTarget;
          ctrl.immed_src = ImmJ;
        end
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      default: begin
      end
    endcase
    // Reset drops any in-flight request immediately, without waiting for a clock edge.
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign bus.pcUpdate   = ctrl.pc_update;
  assign bus.pcSrc      = ctrl.pc_src;
  assign bus.irWrite    = ctrl.ir_write;
  assign bus.addrSrc    = ctrl.addr_src;
  assign bus.memRead    = ctrl.mem_read;
  assign bus.memWrite   = ctrl.mem_write;
  assign bus.regSrc     = ctrl.reg_src;
  assign bus.regWrite   = ctrl.reg_write;
  assign bus.immedSrc   = ctrl.immed_src;
  assign bus.aluSrcA    = ctrl.alu_src_a;
  assign bus.aluSrcB    = ctrl.alu_src_b;
  assign bus.aluOp      = ctrl.alu_op;
  assign bus.halted     = ctrl.halted;
  assign bus.halt_cause = cause_q;

`ifdef MCU_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             retire;

  // An instruction retires when the FSM returns to FETCH from a completing state.
  assign retire = (state_d == StFetch) &&
                  ((state_q == StExec) || (state_q == StMemWb) || (state_q == StMemWr) ||
                   (state_q == StBranch) || (state_q == StJump));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != StHalt) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle pushes the expected control vector,
// a negedge monitor pops and compares against the DUT outputs.
module tb_mc_control_fsm;
  localparam int unsigned CntW = 32;

  // Bench-side state labels for the expected-value table.
  localparam int SF = 0, SD = 1, SE = 2, SMA = 3, SMR = 4, SMB = 5, SMW = 6, SB = 7, SJ = 8,
                 SH = 9, SRST = 10;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

`ifdef MCU_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [22:0]      ctl;
    logic [CntW-1:0]  cyc;
    logic [CntW-1:0]  ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exp_t            exp_q[$];
  exp_t            mon_e;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [CntW-1:0] e_cyc = '0;
  logic [CntW-1:0] e_ret = '0;
  logic [1:0]      e_cause = 2'd0;

  mc_control_fsm_if #(.CNT_W(CntW)) bus ();

  mc_control_fsm #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CntW),
    .TMR_W      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected controls from the state table; packing order matches the monitor.
  function automatic logic [22:0] exp_ctl(int st, logic [6:0] op, logic mr, logic bt,
                                          logic [1:0] cause);
    logic       pcu, irw, adr, mrd, mwr, rgw, hlt;
    logic [1:0] pcs, rgs, asa, asb;
    logic [2:0] imm, alu;
    pcu = 0; irw = 0; adr = 0; mrd = 0; mwr = 0; rgw = 0; hlt = 0;
    pcs = 0; rgs = 0; asa = 0; asb = 0; imm = 0; alu = 0;
    case (st)
      SF: begin
        mrd = 1; asa = 2'd1; asb = 2'd2;
        if (mr) begin irw = 1; pcu = 1; end
      end
      SE: begin
        rgw = 1;
        if (op == OP_R) begin alu = 3'd2; end
        else if (op == OP_I) begin asb = 2'd1; alu = 3'd3; end
        else if (op == OP_LUI) begin asa = 2'd3; asb = 2'd1; imm = 3'd3; end
        else if (op == OP_AUI) begin asa = 2'd2; asb = 2'd1; imm = 3'd3; end
      end
      SMA: begin asb = 2'd1; imm = (op == OP_LD) ? 3'd0 : 3'd1; end
      SMR: begin mrd = 1; adr = 1; end
      SMB: begin rgw = 1; rgs = 2'd1; end
      SMW: begin mwr = 1; adr = 1; end
      SB:  begin alu = 3'd1; imm = 3'd2; pcs = 2'd1; pcu = bt; end
      SJ: begin
        rgw = 1; rgs = 2'd2; pcu = 1;
        if (op == OP_JLR) begin asb = 2'd1; pcs = 2'd2; end
        else begin pcs = 2'd1; imm = 3'd4; end
      end
      SH: hlt = 1;
      default: ;
    endcase
    return {pcu, pcs, irw, adr, mrd, mwr, rgs, rgw, imm, asa, asb, alu, hlt, cause};
  endfunction

  function automatic exp_t mk(string nm, logic [22:0] ctl);
    exp_t e;
    e.name = nm;
    e.ctl  = ctl;
    e.cyc  = Perf ? e_cyc : '0;
    e.ret  = Perf ? e_ret : '0;
    return e;
  endfunction

  // One clock of stimulus: drive inputs, queue the expectation, advance the counter model.
  task automatic step(input string nm, input int st, input logic [6:0] op, input logic mr,
                      input logic bt, input logic er);
    bus.opcode    = op;
    bus.mem_ready = mr;
    bus.br_taken  = bt;
    bus.error     = er;
    exp_q.push_back(mk(nm, exp_ctl(st, op, mr, bt, e_cause)));
    @(posedge clk);
    #1;
    if (st != SH) e_cyc = e_cyc + 1;
    if (!er && ((st == SE) || (st == SMB) || (st == SB) || (st == SJ) ||
                ((st == SMW) && mr))) e_ret = e_ret + 1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.br_taken = 1'b0; bus.error = 1'b0;
    e_cyc = '0; e_ret = '0; e_cause = 2'd0;
    exp_q.push_back(mk(nm, 23'd0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [22:0] act;
      mon_e = exp_q.pop_front();
      act = {bus.pcUpdate, bus.pcSrc, bus.irWrite, bus.addrSrc, bus.memRead, bus.memWrite,
             bus.regSrc, bus.regWrite, bus.immedSrc, bus.aluSrcA, bus.aluSrcB, bus.aluOp,
             bus.halted, bus.halt_cause};
      n_cmp++;
      if ({act, bus.cycle_cnt, bus.instret_cnt} !== {mon_e.ctl, mon_e.cyc, mon_e.ret}) begin
        n_bad++;
        $display("FAIL %s: got ctl=%h cyc=%0d ret=%0d, want ctl=%h cyc=%0d ret=%0d",
                 mon_e.name, act, bus.cycle_cnt, bus.instret_cnt,
                 mon_e.ctl, mon_e.cyc, mon_e.ret);
      end
    end
  end

  initial begin
    do_reset("reset");

    // ADDI
    step("addi_fetch", SF, OP_I, 1, 0, 0);
    step("addi_dec",   SD, OP_I, 1, 0, 0);
    step("addi_exec",  SE, OP_I, 1, 0, 0);
    // LW, two stalled cycles in MEM_RD
    step("lw_fetch", SF,  OP_LD, 1, 0, 0);
    step("lw_dec",   SD,  OP_LD, 1, 0, 0);
    step("lw_addr",  SMA, OP_LD, 1, 0, 0);
    step("lw_rd0",   SMR, OP_LD, 0, 0, 0);
    step("lw_rd1",   SMR, OP_LD, 0, 0, 0);
    step("lw_rd2",   SMR, OP_LD, 1, 0, 0);
    step("lw_wb",    SMB, OP_LD, 1, 0, 0);
    // SW with one stall
    step("sw_fetch", SF,  OP_ST, 1, 0, 0);
    step("sw_dec",   SD,  OP_ST, 1, 0, 0);
    step("sw_addr",  SMA, OP_ST, 1, 0, 0);
    step("sw_wr0",   SMW, OP_ST, 0, 0, 0);
    step("sw_wr1",   SMW, OP_ST, 1, 0, 0);
    // BEQ not taken, then taken
    step("beq_nt_fetch", SF, OP_BR, 1, 0, 0);
    step("beq_nt_dec",   SD, OP_BR, 1, 0, 0);
    step("beq_nt",       SB, OP_BR, 1, 0, 0);
    step("beq_t_fetch",  SF, OP_BR, 1, 1, 0);
    step("beq_t_dec",    SD, OP_BR, 1, 1, 0);
    step("beq_t",        SB, OP_BR, 1, 1, 0);
    // Remaining classes
    step("add_fetch",   SF, OP_R,   1, 0, 0);
    step("add_dec",     SD, OP_R,   1, 0, 0);
    step("add_exec",    SE, OP_R,   1, 0, 0);
    step("lui_fetch",   SF, OP_LUI, 1, 0, 0);
    step("lui_dec",     SD, OP_LUI, 1, 0, 0);
    step("lui_exec",    SE, OP_LUI, 1, 0, 0);
    step("auipc_fetch", SF, OP_AUI, 1, 0, 0);
    step("auipc_dec",   SD, OP_AUI, 1, 0, 0);
    step("auipc_exec",  SE, OP_AUI, 1, 0, 0);
    step("jal_fetch",   SF, OP_JAL, 1, 0, 0);
    step("jal_dec",     SD, OP_JAL, 1, 0, 0);
    step("jal_jump",    SJ, OP_JAL, 1, 0, 0);
    step("jalr_fetch",  SF, OP_JLR, 1, 0, 0);
    step("jalr_dec",    SD, OP_JLR, 1, 0, 0);
    step("jalr_jump",   SJ, OP_JLR, 1, 0, 0);
    // Three stalls in FETCH stay just under the 4-cycle watchdog
    step("fw_0",    SF, OP_I, 0, 0, 0);
    step("fw_1",    SF, OP_I, 0, 0, 0);
    step("fw_2",    SF, OP_I, 0, 0, 0);
    step("fw_3",    SF, OP_I, 1, 0, 0);
    step("fw_dec",  SD, OP_I, 1, 0, 0);
    step("fw_exec", SE, OP_I, 1, 0, 0);
    // Illegal opcode halts after DECODE; counters frozen, later error ignored
    step("ill_fetch", SF, OP_BAD, 1, 0, 0);
    step("ill_dec",   SD, OP_BAD, 1, 0, 0);
    e_cause = 2'd2;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("ill_halt%0d", i), SH, OP_BAD, 1, 0, (i == 5) ? 1'b1 : 1'b0);
    end

    // Watchdog: four stalled FETCH cycles halt with cause 3
    do_reset("reset2");
    step("to_0", SF, OP_I, 0, 0, 0);
    step("to_1", SF, OP_I, 0, 0, 0);
    step("to_2", SF, OP_I, 0, 0, 0);
    step("to_3", SF, OP_I, 0, 0, 0);
    e_cause = 2'd3;
    step("to_halt0", SH, OP_I, 0, 0, 0);
    step("to_halt1", SH, OP_I, 0, 0, 1);
    step("to_halt2", SH, OP_I, 0, 0, 0);

    // Error during MEM_WR: outputs still asserted that cycle, then HALT cause 1
    do_reset("reset3");
    step("er_fetch", SF,  OP_ST, 1, 0, 0);
    step("er_dec",   SD,  OP_ST, 1, 0, 0);
    step("er_addr",  SMA, OP_ST, 1, 0, 0);
    step("er_wr",    SMW, OP_ST, 0, 0, 1);
    e_cause = 2'd1;
    step("er_halt",  SH,  OP_ST, 0, 0, 0);

    // Async reset between edges: outputs drop at once, release also between edges
    rst_n = 1'b0;
    bus.opcode = OP_I; bus.mem_ready = 1'b1; bus.br_taken = 1'b0; bus.error = 1'b0;
    e_cyc = '0; e_ret = '0; e_cause = 2'd0;
    exp_q.push_back(mk("async_rst", 23'd0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e_cyc = 1;  // half-cycle in FETCH with mem_ready=1 before that edge
    step("ar_dec",   SD, OP_I, 1, 0, 0);
    step("ar_exec",  SE, OP_I, 1, 0, 0);
    step("ar_fetch", SF, OP_I, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
